// File: rtl/bicubic_tile_collector_pkg.sv
// Shared constants and helpers for the bicubic tile collector
// and the upsampler wrapper.
package bicubic_tile_collector_pkg;

  localparam int CHANNEL_WIDTH = 8;
  localparam int TILE_PIX      = 16;
  localparam int ROW_PIX       = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Pixel k of a row-major window; k=0 is upsampler input p1.
  function automatic logic [CHANNEL_WIDTH-1:0] win_pix(
    input logic [TILE_PIX*CHANNEL_WIDTH-1:0] win,
    input logic [3:0]                        idx
  );
    return win[idx*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  endfunction

endpackage

// File: rtl/bicubic_tile_collector_buf.sv
// 16-pixel tile store: one pixel write port, one 4-pixel row read port.
// The array is left unreset; readers gate its output.
module bicubic_tile_buf
  import bicubic_tile_collector_pkg::*;
#(
  parameter int CW = CHANNEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_widx,
  input  logic [CW-1:0]         i_wdata,
  input  logic [1:0]            i_ridx,
  output logic [ROW_PIX*CW-1:0] o_rdata
);

  logic [CW-1:0] r_mem [TILE_PIX];

  // capture one interpolated pixel per beat
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  // gather the four columns of the selected row
  always_comb begin
    o_rdata = '0;
    for (int c = 0; c < ROW_PIX; c++) begin
      o_rdata[c*CW +: CW] = r_mem[{i_ridx, 2'(c)}];
    end
  end

endmodule

// File: rtl/bicubic_tile_collector.sv
// Drives one 4x4 window into the bicubic upsampler, gathers its 16
// serial pixels into a tile and streams the tile out row by row.
module bicubic_tile_collector
  import bicubic_tile_collector_pkg::*;
#(
  parameter int CW = CHANNEL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [16*CW-1:0]  win_data,
  output logic              bf_req_valid,
  input  logic              bcci_req_ready,
  output logic [16*CW-1:0]  bf_win,
  input  logic              bcci_rsp_valid,
  output logic              bf_rsp_ready,
  input  logic [CW-1:0]     bcci_rsp_data1,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [4*CW-1:0]   row_data,
  output logic              row_last,
  output logic              sync_err
);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [1:0]       r_row;
  logic             r_full;
  logic [16*CW-1:0] r_act;
  logic [16*CW-1:0] r_pend;
  logic             r_sync_err;

  logic             w_issue;
  logic             w_drain;
  logic             w_win_hs;
  logic             w_beat;
  logic             w_resync;
  logic             w_row_hs;
  logic             w_tile_done;
  logic [4*CW-1:0]  w_row;

  assign w_issue  = (r_state == ST_ISSUE);
  assign w_drain  = (r_state == ST_DRAIN);
  assign w_win_hs = win_valid & ~r_full;
  // The first beat must coincide with the upsampler's first state.
  assign w_beat   = w_issue & bcci_rsp_valid &
                    ((r_cnt != 4'd0) | bcci_req_ready);
  assign w_resync = w_issue & bcci_rsp_valid &
                    (r_cnt == 4'd0) & ~bcci_req_ready;
  assign w_row_hs = w_drain & row_ready;
  assign w_tile_done = w_row_hs & (r_row == 2'd3);

  assign win_ready    = ~r_full;
  assign bf_req_valid = w_issue;
  assign bf_rsp_ready = w_issue;
  assign bf_win       = r_act;
  assign row_valid    = w_drain;
  assign row_last     = w_drain & (r_row == 2'd3);
  assign row_data     = w_drain ? w_row : '0;
  assign sync_err     = r_sync_err;

  bicubic_tile_buf #(
    .CW (CW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_beat),
    .i_widx  (r_cnt),
    .i_wdata (bcci_rsp_data1),
    .i_ridx  (r_row),
    .o_rdata (w_row)
  );

  // control FSM, window slots and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_row      <= '0;
      r_full     <= 1'b0;
      r_act      <= '0;
      r_pend     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_resync) r_sync_err <= 1'b1;
      // park a window arriving while busy, unless it goes
      // straight to the active slot at the end of a tile
      if (!(r_state == ST_IDLE) && w_win_hs && !w_tile_done) begin
        r_pend <= win_data;
        r_full <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_win_hs) begin
            r_act   <= win_data;
            r_cnt   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_row   <= '0;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_row_hs) begin
            r_row <= r_row + 2'd1;
            if (r_row == 2'd3) begin
              r_cnt <= '0;
              if (r_full) begin
                r_act   <= r_pend;
                r_full  <= 1'b0;
                r_state <= ST_ISSUE;
              end else if (w_win_hs) begin
                r_act   <= win_data;
                r_state <= ST_ISSUE;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
